// File: rtl/tdc_thermo_encoder_pkg.sv
// Shared constants, width helper and the fine-time result type.
// Used by the thermometer encoder and the event formatter.
package tdc_pkg;

    localparam int TDC_NTAPS_MIN = 4;
    localparam int TDC_NTAPS_MAX = 256;
    localparam int TDC_BW_MAX    = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // bin is sized for the widest legal delay line; narrower lines zero-extend
    typedef struct packed {
        logic [TDC_BW_MAX-1:0] bin;
        logic                  no_hit;
        logic                  bubble_err;
    } tdc_fine_t;

endpackage

// File: rtl/tdc_thermo_encoder_if.sv
// Sample/result bundle between the delay-line sampler, the encoder and the formatter.
interface tdc_thermo_encoder_if
    import tdc_pkg::*;
#(
    parameter int NTAPS = 16
);
    localparam int BW = clog2(NTAPS);

    logic             enable;
    logic             sample;
    logic [NTAPS-1:0] thermo;
    logic             valid_out;
    logic [BW-1:0]    bin;
    logic             no_hit;
    logic             bubble_err;
    tdc_fine_t        fine;

    // Formatter-side view of the result in the shared packed layout
    assign fine = '{bin: TDC_BW_MAX'(bin), no_hit: no_hit, bubble_err: bubble_err};

    modport master (
        output enable, sample, thermo,
        input  valid_out, bin, no_hit, bubble_err, fine
    );

    modport slave (
        input  enable, sample, thermo,
        output valid_out, bin, no_hit, bubble_err
    );

endinterface

// File: rtl/tdc_thermo_prio.sv
// Combinational lowest-set-bit finder; all-zero input reports index NTAPS-1.
module tdc_thermo_prio
    import tdc_pkg::*;
#(
    parameter  int NTAPS = 16,
    localparam int BW    = clog2(NTAPS)
) (
    input  logic [NTAPS-1:0] vec,
    output logic [BW-1:0]    idx,
    output logic             zero
);

    always_comb begin
        idx  = BW'(NTAPS - 1);
        zero = ~|vec;
        for (int k = NTAPS - 1; k >= 0; k--) begin
            if (vec[k]) idx = BW'(k);
        end
    end

endmodule

// File: rtl/tdc_thermo_encoder.sv
// Pipelined thermometer-to-binary encoder: capture, bubble filter, encode, output.
// A result leaves three edges after its capture edge; valid bits ride with the data.
module tdc_thermo_encoder
    import tdc_pkg::*;
#(
    parameter int NTAPS         = 16,
    parameter bit BUBBLE_FILTER = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    tdc_thermo_encoder_if.slave  io
);

    localparam int BW     = clog2(NTAPS);
    localparam int TW     = NTAPS - 1;
    localparam int STAGES = 3;
    localparam bit NTAPS_OK = (NTAPS >= TDC_NTAPS_MIN) && (NTAPS <= TDC_NTAPS_MAX) &&
                              ((NTAPS & (NTAPS - 1)) == 0);

    generate
        if (!NTAPS_OK) begin : g_bad_ntaps
            $error("tdc_thermo_encoder: NTAPS must be a power of 2 in [4,256]");
        end
    endgenerate

    // vld_pipe[0]=capture, [1]=filter, [2]=encode, [3]=output
    logic [STAGES:0]  vld_pipe;
    logic             accept;
    logic [NTAPS-1:0] raw;
    logic [NTAPS-1:0] filt;
    logic [NTAPS-1:0] filt_q;
    logic [TW-1:0]    trans;
    logic             multi_trans;
    logic             err_q;
    logic [BW-1:0]    prio_idx;
    logic             prio_zero;
    logic [BW-1:0]    bin3;
    logic             no_hit3;
    logic             err3;
    logic [BW-1:0]    bin_q;
    logic             no_hit_q;
    logic             err_out_q;

    assign accept = io.sample & io.enable;

    // Majority filter; edge taps replicate themselves so they pass through unchanged
    generate
        for (genvar k = 0; k < NTAPS; k++) begin : g_filt
            localparam int LO = (k == 0) ? 0 : k - 1;
            localparam int HI = (k == NTAPS - 1) ? NTAPS - 1 : k + 1;
            if (BUBBLE_FILTER) begin : g_maj
                assign filt[k] = (raw[LO] & raw[k]) | (raw[k] & raw[HI]) | (raw[LO] & raw[HI]);
            end else begin : g_raw
                assign filt[k] = raw[k];
            end
        end

        for (genvar k = 1; k < NTAPS; k++) begin : g_trans
            assign trans[k-1] = raw[k] ^ raw[k-1];
        end
    endgenerate

    // More than one transition <=> clearing the lowest set bit leaves something
    assign multi_trans = |(trans & (trans - TW'(1)));

    tdc_thermo_prio #(.NTAPS(NTAPS)) u_prio (
        .vec  (filt_q),
        .idx  (prio_idx),
        .zero (prio_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            raw       <= '0;
            filt_q    <= '0;
            err_q     <= 1'b0;
            bin3      <= '0;
            no_hit3   <= 1'b0;
            err3      <= 1'b0;
            bin_q     <= '0;
            no_hit_q  <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
            if (accept) raw <= io.thermo;
            filt_q  <= filt;
            err_q   <= multi_trans;
            bin3    <= prio_idx;
            no_hit3 <= prio_zero;
            err3    <= err_q;
            if (vld_pipe[2]) begin
                bin_q     <= bin3;
                no_hit_q  <= no_hit3;
                err_out_q <= err3;
            end else begin
                bin_q     <= '0;
                no_hit_q  <= 1'b0;
                err_out_q <= 1'b0;
            end
        end
    end

    assign io.valid_out  = vld_pipe[STAGES];
    assign io.bin        = bin_q;
    assign io.no_hit     = no_hit_q;
    assign io.bubble_err = err_out_q;

endmodule

// File: tb/tb_tdc_thermo_encoder.sv
// Directed and random checks of the 16-tap encoder, filtered and unfiltered builds side by side.
module tb_tdc_thermo_encoder;

    typedef struct {
        bit v;
        int bin;
        bit nh;
        bit err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        sample;
    logic [15:0] thermo;

    int checks   = 0;
    int failures = 0;

    exp_t h1[4];
    exp_t h0[4];

    tdc_thermo_encoder_if #(.NTAPS(16)) io1 ();
    tdc_thermo_encoder_if #(.NTAPS(16)) io0 ();

    assign io1.enable = enable;
    assign io1.sample = sample;
    assign io1.thermo = thermo;
    assign io0.enable = enable;
    assign io0.sample = sample;
    assign io0.thermo = thermo;

    tdc_thermo_encoder #(.NTAPS(16), .BUBBLE_FILTER(1'b1)) dut_f1 (
        .clk (clk),
        .rst (rst),
        .io  (io1)
    );

    tdc_thermo_encoder #(.NTAPS(16), .BUBBLE_FILTER(1'b0)) dut_f0 (
        .clk (clk),
        .rst (rst),
        .io  (io0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from the rules: majority vote, transition count, lowest hit
    function automatic exp_t model(input logic [15:0] r, input bit filt_on);
        exp_t e;
        int n_trans;
        int votes;
        bit f[16];
        n_trans = 0;
        for (int k = 1; k < 16; k++) if (r[k] != r[k-1]) n_trans++;
        for (int k = 0; k < 16; k++) begin
            votes = int'(r[(k == 0) ? 0 : k - 1]) + int'(r[k]) + int'(r[(k == 15) ? 15 : k + 1]);
            f[k] = filt_on ? (votes >= 2) : bit'(r[k]);
        end
        e.v   = 1'b1;
        e.bin = 15;
        e.nh  = 1'b1;
        e.err = (n_trans > 1);
        for (int k = 15; k >= 0; k--) begin
            if (f[k]) begin
                e.bin = k;
                e.nh  = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cmp_dut(input string tag, input exp_t e, input logic v, input logic [3:0] b,
                           input logic nh, input logic er, input logic [7:0] fb);
        chk({tag, "_valid"}, 32'(v), 32'(e.v));
        chk({tag, "_bin"}, 32'(b), 32'(e.bin));
        chk({tag, "_no_hit"}, 32'(nh), 32'(e.nh));
        chk({tag, "_bubble_err"}, 32'(er), 32'(e.err));
        chk({tag, "_fine_bin"}, 32'(fb), 32'(e.bin));
    endtask

    // One clock: advance the reference delay line with what the DUT saw, then compare
    task automatic tick();
        exp_t z;
        exp_t n1;
        exp_t n0;
        bit acc;
        z = '{v: 1'b0, bin: 0, nh: 1'b0, err: 1'b0};
        @(posedge clk);
        acc = sample && enable && !rst;
        n1 = acc ? model(thermo, 1'b1) : z;
        n0 = acc ? model(thermo, 1'b0) : z;
        for (int i = 3; i > 0; i--) begin
            h1[i] = rst ? z : h1[i-1];
            h0[i] = rst ? z : h0[i-1];
        end
        h1[0] = n1;
        h0[0] = n0;
        #1;
        cmp_dut("f1", h1[3], io1.valid_out, io1.bin, io1.no_hit, io1.bubble_err, io1.fine.bin);
        cmp_dut("f0", h0[3], io0.valid_out, io0.bin, io0.no_hit, io0.bubble_err, io0.fine.bin);
    endtask

    task automatic pulse(input logic [15:0] code);
        thermo = code;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        repeat (3) tick();
    endtask

    function automatic logic [15:0] rand_code();
        int k;
        logic [15:0] c;
        logic [15:0] ones;
        ones = 16'hFFFF;
        k = int'($urandom_range(0, 16));
        c = (k == 16) ? 16'h0000 : (ones << k);
        case ($urandom_range(0, 3))
            0: c = c ^ (16'h0001 << $urandom_range(0, 15));
            1: c = 16'($urandom);
            default: ;
        endcase
        return c;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            h1[i] = '{v: 1'b0, bin: 0, nh: 1'b0, err: 1'b0};
            h0[i] = '{v: 1'b0, bin: 0, nh: 1'b0, err: 1'b0};
        end
        rst    = 1'b1;
        enable = 1'b0;
        sample = 1'b0;
        thermo = 16'h0000;

        tick();
        tick();
        chk("rst_valid", 32'(io1.valid_out), 32'd0);
        chk("rst_bin", 32'(io1.bin), 32'd0);
        chk("rst_no_hit", 32'(io1.no_hit), 32'd0);
        chk("rst_bubble_err", 32'(io1.bubble_err), 32'd0);

        rst    = 1'b0;
        enable = 1'b1;

        // Clean code, exact latency
        thermo = 16'hFFF0;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        tick();
        chk("clean_early1", 32'(io1.valid_out), 32'd0);
        tick();
        chk("clean_early2", 32'(io1.valid_out), 32'd0);
        tick();
        chk("clean_valid", 32'(io1.valid_out), 32'd1);
        chk("clean_bin", 32'(io1.bin), 32'd4);
        chk("clean_no_hit", 32'(io1.no_hit), 32'd0);
        chk("clean_err", 32'(io1.bubble_err), 32'd0);
        tick();
        chk("clean_after", 32'(io1.valid_out), 32'd0);

        pulse(16'h0000);
        chk("empty_bin", 32'(io1.bin), 32'd15);
        chk("empty_no_hit", 32'(io1.no_hit), 32'd1);
        pulse(16'hFFFF);
        chk("full_bin", 32'(io1.bin), 32'd0);
        chk("full_no_hit", 32'(io1.no_hit), 32'd0);

        pulse(16'hFFF2);
        chk("bubble_f1_bin", 32'(io1.bin), 32'd4);
        chk("bubble_f1_err", 32'(io1.bubble_err), 32'd1);
        chk("bubble_f0_bin", 32'(io0.bin), 32'd1);
        chk("bubble_f0_err", 32'(io0.bubble_err), 32'd1);

        // Streaming four back-to-back samples
        sample = 1'b1;
        thermo = 16'hFFFE; tick();
        thermo = 16'hFFFC; tick();
        thermo = 16'hFFF8; tick();
        thermo = 16'hFFF0; tick();
        sample = 1'b0;
        chk("stream_bin0", 32'(io1.bin), 32'd1);
        tick();
        chk("stream_bin1", 32'(io1.bin), 32'd2);
        tick();
        chk("stream_bin2", 32'(io1.bin), 32'd3);
        tick();
        chk("stream_bin3", 32'(io1.bin), 32'd4);
        chk("stream_valid3", 32'(io1.valid_out), 32'd1);
        tick();
        chk("stream_end", 32'(io1.valid_out), 32'd0);

        // Sample strobes while disabled produce nothing
        enable = 1'b0;
        sample = 1'b1;
        repeat (6) begin
            tick();
            chk("disabled_valid", 32'(io1.valid_out), 32'd0);
        end

        // Enable drops after an accepted sample
        enable = 1'b1;
        thermo = 16'hFFF0;
        tick();
        enable = 1'b0;
        tick();
        tick();
        tick();
        chk("en_drop_valid", 32'(io1.valid_out), 32'd1);
        chk("en_drop_bin", 32'(io1.bin), 32'd4);
        tick();
        chk("en_drop_after", 32'(io1.valid_out), 32'd0);

        // Reset while a sample is in flight
        enable = 1'b1;
        sample = 1'b1;
        thermo = 16'hFF00;
        tick();
        sample = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(io1.valid_out), 32'd0);
        rst    = 1'b0;
        sample = 1'b1;
        thermo = 16'hFFC0;
        tick();
        chk("midrst_discard", 32'(io1.valid_out), 32'd0);
        chk("midrst_bin", 32'(io1.bin), 32'd0);
        sample = 1'b0;
        tick();
        tick();
        chk("midrst_quiet", 32'(io1.valid_out), 32'd0);
        tick();
        chk("postrst_valid", 32'(io1.valid_out), 32'd1);
        chk("postrst_bin", 32'(io1.bin), 32'd6);

        // Random traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(0, 49) == 0);
            enable = ($urandom_range(0, 7) != 0);
            sample = ($urandom_range(0, 3) != 0);
            thermo = rand_code();
            tick();
        end
        rst    = 1'b0;
        sample = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdc_thermo_encoder.md
# tdc_thermo_encoder

Pipelined, parametrised thermometer-to-binary encoder for the TDC fine-time path. It captures an NTAPS-bit delay-line code on a sample strobe and applies optional 3-tap majority bubble correction. It then emits the index of the lowest set tap, with valid, no-hit and bubble-error flags, after a fixed latency. It sits between the delay-line sampling flops and the TDC event formatter, and it supersedes the combinational 16-tap encoder.

## Interface
- NTAPS, 16, number of delay-line taps; power of 2, 4 ≤ NTAPS ≤ 256
- BW, log2(NTAPS), derived localparam, binary output width; not overridable
- BUBBLE_FILTER, 1, 1 = majority-filter the captured code before encoding; 0 = encode the raw code
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- enable  input  1  gates new captures; does not affect results already in flight
- sample  input  1  capture strobe; captures thermo when enable=1
- thermo  input  NTAPS  thermometric delay-line code
- valid_out  output  1  one-cycle pulse per accepted sample
- bin  output  BW  lowest set tap index
- no_hit  output  1  filtered code was all zeros
- bubble_err  output  1  raw code had more than one level transition

## Operation
- Accept condition: a sample is accepted on edge e when sample=1, enable=1 and rst=0 at e.
- S1 (capture): on acceptance, raw ← thermo and v1 ← 1; otherwise v1 ← 0.
- S2 (filter): f[k] = maj(r[k-1], r[k], r[k+1]).
  - Boundary taps use replication: r[-1]=r[0] and r[NTAPS]=r[NTAPS-1], so taps 0 and NTAPS-1 pass through unchanged.
  - When BUBBLE_FILTER=0, f = raw.
  - err2 = 1 when the count of k in 1..NTAPS-1 with raw[k] != raw[k-1] is greater than 1; this is always computed on the raw code.
- S3 (encode):
  - bin = smallest k with f[k]=1.
  - If f = 0: bin = NTAPS-1 and no_hit = 1.
  - All-ones code gives bin = 0.
- Output gating: when valid_out=0, bin, no_hit and bubble_err are all 0.
- Stage isolation: a valid bit travels with its data and each stage is independent, so there are no bubbles, no stalls and no backpressure.

## Timing
- Latency: a sample accepted at edge n gives valid_out=1 with its data during the cycle after edge n+3.
- Throughput: one sample per cycle. Back-to-back samples produce back-to-back valid_out pulses, in order.
- Reset values: valid_out=0, bin=0, no_hit=0, bubble_err=0. All internal valid bits and data registers are 0.
- Reset mid-operation: rst=1 at any edge clears every stage. In-flight results are discarded and never emitted, and a sample at that edge is ignored. The first acceptable sample is at the first edge with rst=0.
- enable falling: samples accepted before the drop still emerge on schedule. enable is sampled only at the S1 edge.
- sample held high with enable=1: one capture per cycle; this is not edge-detected.
- No wrap-around or overflow: the block has no counters and no state machine beyond the valid pipeline.

## Structure
- Package tdc_pkg holds:
  - the clog2 function used to derive BW;
  - the NTAPS range-check constants;
  - the tdc_fine_t typedef (bin, no_hit, bubble_err) shared with the event formatter.
- One sub-module, tdc_thermo_prio: a purely combinational lowest-set-bit finder with parameter NTAPS. It returns the index and an all-zero flag and is instantiated in S3.
- The bubble filter and the transition counter are inline generate loops in the top module.

## Test plan
All cases use NTAPS=16 and BUBBLE_FILTER=1 unless stated.
- Clean code: thermo=16'hFFF0, one sample pulse at edge n -> valid_out=1 after edge n+3 only, bin=4, no_hit=0, bubble_err=0.
- Empty and full codes: thermo=16'h0000 -> bin=15, no_hit=1. thermo=16'hFFFF -> bin=0, no_hit=0.
- Bubble, both filter settings, thermo=16'hFFF2:
  - BUBBLE_FILTER=1 -> bin=4, bubble_err=1.
  - BUBBLE_FILTER=0 -> bin=1, bubble_err=1.
- Streaming: samples on 4 consecutive edges with 16'hFFFE, 16'hFFFC, 16'hFFF8, 16'hFFF0 -> 4 consecutive valid_out cycles with bin=1,2,3,4.
- Enable handling:
  - sample=1 with enable=0 -> no valid_out for 6 cycles, outputs stay 0.
  - sample at edge n, enable dropped at n+1 -> result still emitted after edge n+3.
- Reset mid-flight: sample 16'hFF00 at edge n, rst=1 at edge n+2 -> no valid_out; all outputs 0. A sample at the first edge after rst deasserts is emitted 3 edges later.
